dbg_hex_rx: RTL and testbench

Debug command receiver: the receive-side counterpart of the SoC debug hex transmitter. It takes UART receive bytes framed as one tag character followed by two lowercase/uppercase hex digits, reassembles each frame into a 16-bit word {tag, value}, and queues it in a small FIFO. The host can inject debug words (breakpoints, pokes, LED tests) into the core over the same serial line. The block sits between the UART receive path and the core's debug input.

---
 rtl/dbg_hex_rx_pkg.sv | 31 +++
 rtl/dbg_fifo.sv | 57 +++++
 rtl/dbg_hex_rx.sv | 151 +++++++++++++++
 tb/tb_dbg_hex_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_hex_rx_pkg.sv
// rtl/dbg_hex_rx_pkg.sv - shared parser states, framing constants and hex decode
//
// Purpose: definitions shared by the debug hex receiver and its testbench.
//   state_t    : parser states S_TAG, S_NIB0, S_NIB1
//   CH_LF/CH_CR: resync bytes
//   hex_to_nib : ASCII hex digit -> {is_hex, nibble}; inverse of the transmitter's hdigit
package dbg_hex_rx_pkg;

  typedef enum logic [1:0] {
    S_TAG  = 2'd0,
    S_NIB0 = 2'd1,
    S_NIB1 = 2'd2
  } state_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  // 'A'-'F' and 'a'-'f' share low nibbles 1..6, so adding 9 yields 10..15
  // without needing the upper bits of the character.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// rtl/dbg_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: small FWFT queue for received debug words.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (clears pointers)
//   push, din   : write request and data; accepted when not full, or when full with a pop
//   pop         : remove head; ignored when empty
//   full, empty : occupancy flags
//   head        : current head entry (valid while !empty)
module dbg_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry a wrap bit: equal means empty, same slot with
  // different wrap bits means full.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head  = r_mem[r_rptr[AW-1:0]];

  // When full, a simultaneous pop frees the slot being written this edge.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dbg_hex_rx.sv
// rtl/dbg_hex_rx.sv - debug command receiver: tag + two hex digits -> queued 16-bit word
//
// Purpose: parses UART bytes framed as <tag><hex><hex> into {tag, value} words
// and queues them in a FWFT FIFO for the core's debug input.
// Build option: define DBG_RX_STATS_EN to implement err_count/drop_count;
// otherwise both ports read 0 and the counters are not built.
// Ports:
//   clk, resetn           : clock, synchronous active-low reset
//   rx_valid, rx_byte     : one-cycle strobe with received byte
//   out_valid, out_ready  : head word available / consumer pops it
//   out_word              : [15:8] tag, [7:0] decoded value (0 when empty)
//   err_count             : malformed or timed-out frames, saturating
//   drop_count            : complete frames lost to a full FIFO, saturating
module dbg_hex_rx
  import dbg_hex_rx_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [7:0]  err_count,
  output logic [7:0]  drop_count
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_tag;
  logic [3:0]    r_hi;
  logic [TW-1:0] r_tmo;

  logic          w_crlf;
  logic [4:0]    w_dec;
  logic          w_is_hex;
  logic [3:0]    w_nib;
  logic          w_tmo_hit;
  logic          w_push;
  logic          w_fifo_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [15:0]   w_head;

  assign w_crlf    = (rx_byte == CH_LF) || (rx_byte == CH_CR);
  assign w_dec     = hex_to_nib(rx_byte);
  assign w_is_hex  = w_dec[4];
  assign w_nib     = w_dec[3:0];
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_TAG;
    else         r_state <= w_next_state;
  end

  // CR/LF is never hex, so in the digit states it falls into the "not a
  // digit" branch and returns to S_TAG; only the error tally tells it apart.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_TAG: begin
        if (rx_valid && !w_crlf) w_next_state = S_NIB0;
      end
      S_NIB0: begin
        if (rx_valid)       w_next_state = w_is_hex ? S_NIB1 : S_TAG;
        else if (w_tmo_hit) w_next_state = S_TAG;
      end
      S_NIB1: begin
        if (rx_valid) begin
          w_next_state = S_TAG;
          w_push       = w_is_hex;
        end else if (w_tmo_hit) begin
          w_next_state = S_TAG;
        end
      end
      default: w_next_state = S_TAG;
    endcase
  end

  // The inter-byte timer idles at zero in S_TAG and restarts on every strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tag <= 8'h00;
      r_hi  <= 4'h0;
      r_tmo <= '0;
    end else begin
      if (r_state == S_TAG && rx_valid && !w_crlf) r_tag <= rx_byte;
      if (r_state == S_NIB0 && rx_valid && w_is_hex) r_hi <= w_nib;
      if (rx_valid || r_state == S_TAG) r_tmo <= '0;
      else                              r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_pop       = out_ready && !w_empty;
  assign w_fifo_push = w_push && (!w_full || w_pop);

  dbg_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_fifo_push),
    .din    ({r_tag, r_hi, w_nib}),
    .pop    (w_pop),
    .full   (w_full),
    .empty  (w_empty),
    .head   (w_head)
  );

  assign out_valid = !w_empty;
  assign out_word  = w_empty ? 16'h0000 : w_head;

`ifdef DBG_RX_STATS_EN
  logic       w_err;
  logic       w_drop;
  logic [7:0] r_err;
  logic [7:0] r_drop;

  // An abort is any exit from a digit state that neither completes the
  // frame nor is a CR/LF resync.
  assign w_err  = (r_state != S_TAG) && (w_next_state == S_TAG) && !w_push &&
                  !(rx_valid && w_crlf);
  assign w_drop = w_push && !w_fifo_push;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err  <= 8'h00;
      r_drop <= 8'h00;
    end else begin
      if (w_err && r_err != 8'hFF)   r_err  <= r_err + 8'd1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign err_count  = r_err;
  assign drop_count = r_drop;
`else
  assign err_count  = 8'h00;
  assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_dbg_hex_rx.sv
// tb/tb_dbg_hex_rx.sv - scoreboard testbench for dbg_hex_rx
module tb_dbg_hex_rx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_word;
  logic [7:0]  err_count;
  logic [7:0]  drop_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_q[$];
  int          m_err = 0;
  int          m_drop = 0;

  dbg_hex_rx #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .err_count  (err_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int stat(input int m);
`ifdef DBG_RX_STATS_EN
    return (m > 255) ? 255 : m;
`else
    return 0 * m;
`endif
  endfunction

  // Monitor: inputs change 1 time unit after posedge, so the negedge sees
  // exactly the handshake the next posedge will act on.
  always @(negedge clk) begin
    logic [15:0] e;
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", out_word);
      end else begin
        e = exp_q.pop_front();
        chk("pop_word", {16'h0, out_word}, {16'h0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic rdy = 1'b0);
    @(posedge clk); #1;
    rx_valid  = 1'b1;
    rx_byte   = b;
    out_ready = rdy;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [7:0] t, input logic [7:0] h, input logic [7:0] l);
    send(t);
    send(h);
    send(l);
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    m_err  = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_word",  {16'h0, out_word}, 32'h0);
    chk("rst_err",   {24'h0, err_count}, 32'h0);
    chk("rst_drop",  {24'h0, drop_count}, 32'h0);
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_word",  {16'h0, out_word}, 32'h0);
    chk("rst_err",   {24'h0, err_count}, 32'h0);
    chk("rst_drop",  {24'h0, drop_count}, 32'h0);
    resetn = 1'b1;

    // "P3c" -> 0x503C visible the cycle after the last digit
    exp_q.push_back(16'h503C);
    frame("P", "3", "c");
    chk("p3c_valid", {31'h0, out_valid}, 32'h1);
    chk("p3c_word",  {16'h0, out_word}, 32'h503C);
    drain(1);
    chk("p3c_empty", {31'h0, out_valid}, 32'h0);

    // uppercase digits, then a bad digit, then recovery
    exp_q.push_back(16'h58AF);
    frame("X", "A", "F");
    drain(1);
    frame("Q", "1", "g");
    m_err++;
    chk("bad_digit_none", {31'h0, out_valid}, 32'h0);
    chk("bad_digit_err", {24'h0, err_count}, stat(m_err));
    exp_q.push_back(16'h5200);
    frame("R", "0", "0");
    chk("r00_valid", {31'h0, out_valid}, 32'h1);
    drain(1);

    // inter-byte timeout, then the next byte starts a fresh frame
    send("M");
    send("4");
    repeat (TIMEOUT + 8) @(posedge clk);
    #1;
    m_err++;
    chk("timeout_err", {24'h0, err_count}, stat(m_err));
    chk("timeout_none", {31'h0, out_valid}, 32'h0);
    exp_q.push_back(16'h37FF);
    frame("7", "f", "f");
    drain(1);
    chk("after_7ff_err", {24'h0, err_count}, stat(m_err));

    // overflow: DEPTH+2 frames with the consumer stalled
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = {8'h41 + 8'(i), 8'h11 * 8'(i)};
      if (i < DEPTH) exp_q.push_back(w);
      else m_drop++;
      frame(8'h41 + 8'(i), 8'h30 + 8'(i), 8'h30 + 8'(i));
    end
    chk("ovf_valid", {31'h0, out_valid}, 32'h1);
    chk("ovf_drop", {24'h0, drop_count}, stat(m_drop));
    drain(DEPTH + 1);
    chk("ovf_drained", {31'h0, out_valid}, 32'h0);

    // full FIFO, last digit coincides with a pop: word accepted
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({8'h41 + 8'(i), 8'h11 * 8'(i)});
      frame(8'h41 + 8'(i), 8'h30 + 8'(i), 8'h30 + 8'(i));
    end
    exp_q.push_back(16'h4544);
    send("E");
    send("4");
    send("4", 1'b1);
    chk("full_pop_drop", {24'h0, drop_count}, stat(m_drop));
    chk("full_pop_valid", {31'h0, out_valid}, 32'h1);
    drain(DEPTH + 1);
    chk("full_pop_empty", {31'h0, out_valid}, 32'h0);

    // CR resync is silent
    do_reset();
    send("K");
    send("5");
    send(8'h0D);
    exp_q.push_back(16'h4B55);
    frame("K", "5", "5");
    chk("resync_err", {24'h0, err_count}, 32'h0);
    chk("resync_word", {16'h0, out_word}, 32'h4B55);
    drain(1);
    chk("resync_single", {31'h0, out_valid}, 32'h0);

    // build up state, then reset mid-frame
    send("Z");
    send("q");
    m_err++;
    for (int i = 0; i < DEPTH + 1; i++) begin
      frame(8'h61 + 8'(i), "1", "2");
      if (i >= DEPTH) m_drop++;
    end
    chk("pre_rst_err", {24'h0, err_count}, stat(m_err));
    chk("pre_rst_drop", {24'h0, drop_count}, stat(m_drop));
    send("M");
    send("1");
    do_reset();
    exp_q.push_back(16'h4E34);
    frame("N", "3", "4");
    chk("post_rst_word", {16'h0, out_word}, 32'h4E34);
    drain(1);

    repeat (2) @(posedge clk);
    #1;
    chk("final_queue", exp_q.size(), 32'h0);
    chk("final_valid", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
